// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
// The execute stage is the master; the unit itself is the slave.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             kill;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, kill, funct3, srca, srcb,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, funct3, srca, srcb,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle on operand magnitudes, then a sign/special-case fix.
// Latency WIDTH+2 cycles from accept to done for every op; a new start is taken only in IDLE.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic             accept, load_res;
    logic [CW-1:0]    count;
    logic [2:0]       op;
    logic [WIDTH-1:0] a_raw, b_mag, hi, lo, result_q;
    logic             a_neg, b_neg;

    // Operand decode at the accept edge: signedness and magnitudes
    logic             a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;

    always_comb begin
        a_signed_in = !(bus.funct3 == 3'b011 || bus.funct3 == 3'b101 || bus.funct3 == 3'b111);
        b_signed_in = (bus.funct3 == 3'b000 || bus.funct3 == 3'b001 ||
                       bus.funct3 == 3'b100 || bus.funct3 == 3'b110);
        a_neg_in    = a_signed_in & bus.srca[WIDTH-1];
        b_neg_in    = b_signed_in & bus.srcb[WIDTH-1];
        a_mag_in    = a_neg_in ? -bus.srca : bus.srca;
        b_mag_in    = b_neg_in ? -bus.srcb : bus.srcb;
    end

    // One iteration: shift-add multiply step or restoring divide step
    logic [WIDTH:0] mul_sum, div_sh, div_diff;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
        div_sh   = {hi, lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_mag};
    end

    // Final sign correction; the signed-overflow divide falls out naturally
    // (magnitudes 2^(W-1)/1 with matching signs), only divide-by-zero is special.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_nxt;

    always_comb begin
        prod     = {hi, lo};
        prod_fix = (a_neg ^ b_neg) ? -prod : prod;
        quo_fix  = (a_neg ^ b_neg) ? -lo : lo;
        rem_fix  = a_neg ? -hi : hi;
        res_nxt  = '0;
        case (op)
            3'b000:         res_nxt = prod_fix[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:         res_nxt = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: res_nxt = (b_mag == '0) ? '1 : quo_fix;
            default:        res_nxt = (b_mag == '0) ? a_raw : rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_res  = 1'b0;
        case (state)
            IDLE: if (bus.start && !bus.kill) begin
                accept    = 1'b1;
                state_nxt = CALC;
            end
            CALC: begin
                if (bus.kill)                       state_nxt = IDLE;
                else if (count == CW'(WIDTH - 1))   state_nxt = FIX;
            end
            FIX: begin
                if (bus.kill) state_nxt = IDLE;
                else begin
                    load_res  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            op       <= '0;
            a_raw    <= '0;
            b_mag    <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                count <= '0;
                op    <= bus.funct3;
                a_raw <= bus.srca;
                b_mag <= b_mag_in;
                a_neg <= a_neg_in;
                b_neg <= b_neg_in;
                hi    <= '0;
                lo    <= a_mag_in;
            end else if (state == CALC) begin
                count <= count + 1'b1;
                if (op[2]) begin
                    hi <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    hi <= mul_sum[WIDTH:1];
                    lo <= {mul_sum[0], lo[WIDTH-1:1]};
                end
            end
            if (load_res) result_q <= res_nxt;
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded random + directed bench for muldiv_unit against an arithmetic RV32M model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] last_exp = '0;
    logic [31:0] exp_q[$];
    int          acc_q[$];

    muldiv_unit_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // RV32M reference from plain 64-bit arithmetic
    function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * $signed(ub); return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic issue_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input bit expect_done);
        int guard = 0;
        while (bus.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy) check("issue_wait_idle", 32'(bus.busy), 32'h0);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.srca   = a;
        bus.srcb   = b;
        if (expect_done) begin
            exp_q.push_back(model(f, a, b));
            acc_q.push_back(cyc + 1);
            last_exp = model(f, a, b);
        end
        @(negedge clk);
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.srca   = $urandom;
        bus.srcb   = $urandom;
    endtask

    // Monitor: every done pulse pops one expectation and checks value and latency
    always @(negedge clk) begin
        int ac;
        logic [31:0] e;
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'h0);
            end else begin
                e  = exp_q.pop_front();
                ac = acc_q.pop_front();
                check("result", bus.result, e);
                check("latency", 32'(cyc - ac + 1), 32'd34);
            end
        end
    end

    logic [2:0]  dir_f[12] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                              3'b101, 3'b111, 3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] dir_a[12] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h7, 32'h7, 32'h5, 32'h5,
                              32'h8000_0000, 32'h8000_0000};
    logic [31:0] dir_b[12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h2,
                              32'h2, 32'h2, 32'h2, 32'h2, 32'h0, 32'h0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] dir_r[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h3, 32'h1,
                              32'hFFFF_FFFF, 32'h5, 32'h8000_0000, 32'h0};

    initial begin
        int guard;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = '0;
        bus.srca   = '0;
        bus.srcb   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_result", bus.result, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Spot-check the reference model against the known answers
        for (int i = 0; i < 12; i++) check("model_table", model(dir_f[i], dir_a[i], dir_b[i]), dir_r[i]);

        // Busy window of a MUL, then the done pulse via the monitor
        issue_op(3'b000, 32'h7, 32'hFFFF_FFFD, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            if (k > 1) @(negedge clk);
            check("busy_window", 32'(bus.busy), 32'h1);
            check("done_early", 32'(bus.done), 32'h0);
        end

        for (int i = 1; i < 12; i++) issue_op(dir_f[i], dir_a[i], dir_b[i], 1'b1);

        // Kill mid-CALC: busy drops, no done, result holds
        issue_op(3'b000, 32'h1234, 32'h5678, 1'b0);
        repeat (9) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_busy", 32'(bus.busy), 32'h0);
        repeat (40) @(negedge clk);
        check("kill_result_held", bus.result, last_exp);

        // Start pulses while busy are ignored
        issue_op(3'b001, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        check("ignored_start_idle", 32'(bus.busy), 32'h0);

        // Kill during DONE still delivers the pulse
        issue_op(3'b110, 32'hFFFF_FF00, 32'h7, 1'b1);
        repeat (33) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_in_done_result", bus.result, last_exp);

        // Kill together with start in IDLE: not accepted
        @(negedge clk);
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        check("kill_start_busy", 32'(bus.busy), 32'h0);

        // Async reset mid-CALC
        issue_op(3'b011, 32'hFFFF_0000, 32'h0001_FFFF, 1'b0);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_done", 32'(bus.done), 32'h0);
        check("arst_result", bus.result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue_op(3'b100, 32'hFFFF_FF9C, 32'h7, 1'b1);

        for (int n = 0; n < 60; n++) issue_op(3'($urandom_range(0, 7)), pick_val(), pick_val(), 1'b1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
